// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl: pipeline sequencing controller for the five-stage LC-3b core.
// Decides per cycle which pipeline registers load, when the front end is flushed,
// and when nops are injected into IF/ID or ID/EX. It tracks an indirect-branch
// wait state with a watchdog, and keeps two debug counters.
module if_id_hazard_ctrl #(
  parameter int unsigned IND_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  input  logic        load_use,
  input  logic        mispredict,
  input  logic        indirect_in_id,
  input  logic        indirect_resolved,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush,
  output logic        branch_stall,
  output logic        bubble_id_ex,
  output logic        ind_timeout,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    IND_WAIT = 1'b1
  } state_t;

  // The wait counter exits IND_WAIT on the cycle it holds this value.
  localparam logic [3:0] WAIT_LAST = 4'(IND_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        pend_mp_q, pend_mp_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        ind_timeout_q, ind_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]  flush_count_q, flush_count_d;
  logic        mp;

  // A mispredict seen while frozen is remembered and acted on once the freeze lifts.
  assign mp = mispredict | pend_mp_q;

  // Prioritised hazard resolution: outputs and control-state next values.
  always_comb begin
    load_pc       = 1'b1;
    load_if_id    = 1'b1;
    load_id_ex    = 1'b1;
    load_ex_mem   = 1'b1;
    load_mem_wb   = 1'b1;
    flush         = 1'b0;
    branch_stall  = 1'b0;
    bubble_id_ex  = 1'b0;
    state_d       = state_q;
    pend_mp_d     = pend_mp_q;
    wait_cnt_d    = wait_cnt_q;
    ind_timeout_d = ind_timeout_q;

    if (reset) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (dcache_stall) begin
      // Whole pipeline frozen; state and wait counter hold.
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      pend_mp_d   = pend_mp_q | mispredict;
    end else if (mp) begin
      // Redirect wins over everything else, including a pending indirect.
      flush      = 1'b1;
      pend_mp_d  = 1'b0;
      wait_cnt_d = 4'd0;
      state_d    = RUN;
    end else if (state_q == IND_WAIT) begin
      branch_stall = 1'b1;
      load_pc      = 1'b0;
      wait_cnt_d   = wait_cnt_q + 4'd1;
      if (indirect_resolved) begin
        load_pc      = 1'b1;
        branch_stall = 1'b0;
        state_d      = RUN;
      end else if (wait_cnt_q == WAIT_LAST) begin
        ind_timeout_d = 1'b1;
        state_d       = RUN;
      end
    end else if (load_use) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      bubble_id_ex = 1'b1;
    end else if (indirect_in_id && !indirect_resolved) begin
      branch_stall = 1'b1;
      load_pc      = 1'b0;
      wait_cnt_d   = 4'd0;
      state_d      = IND_WAIT;
    end else if (icache_stall) begin
      // IF/ID zeroes its own input while the fetch is incomplete.
      load_pc = 1'b0;
    end
  end

  // Debug counters: saturating stall count, wrapping flush count.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!load_pc && !reset && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (flush) begin
      flush_count_d = flush_count_q + 8'd1;
    end
  end

  // State register; reset discards any pending mispredict or indirect wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      pend_mp_q      <= 1'b0;
      wait_cnt_q     <= 4'd0;
      ind_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      pend_mp_q      <= pend_mp_d;
      wait_cnt_q     <= wait_cnt_d;
      ind_timeout_q  <= ind_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign ind_timeout  = ind_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Testbench for if_id_hazard_ctrl: directed per-cycle vectors feed a queue of
// expected responses; a negedge monitor pops and compares each cycle.
module tb_if_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        icache_stall = 1'b0, dcache_stall = 1'b0, load_use = 1'b0;
  logic        mispredict = 1'b0, indirect_in_id = 1'b0, indirect_resolved = 1'b0;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush, branch_stall, bubble_id_ex, ind_timeout;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  if_id_hazard_ctrl #(.IND_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .load_use(load_use), .mispredict(mispredict),
    .indirect_in_id(indirect_in_id), .indirect_resolved(indirect_resolved),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush(flush), .branch_stall(branch_stall), .bubble_id_ex(bubble_id_ex),
    .ind_timeout(ind_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [4:0]  loads;
    logic        fl, bs, bub, to, chk_cnt;
    logic [15:0] sc;
    logic [7:0]  fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_vec = 0;

  // Expected register values, tracked alongside the directed vectors.
  logic [15:0] m_sc = 16'd0;
  logic [7:0]  m_fc = 8'd0;
  logic        m_to = 1'b0;

  localparam logic [4:0] ALL   = 5'b11111;
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] PCOFF = 5'b01111;
  localparam logic [4:0] LU    = 5'b00111;

  // One cycle: drive inputs after the edge, queue the hand-computed response.
  task automatic cyc(input logic rst, input logic ic, input logic dc, input logic lu,
                     input logic mpi, input logic iid, input logic ir,
                     input logic [4:0] e_loads, input logic e_fl, input logic e_bs,
                     input logic e_bub, input logic chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; icache_stall = ic; dcache_stall = dc; load_use = lu;
    mispredict = mpi; indirect_in_id = iid; indirect_resolved = ir;
    e.idx = n_vec; e.loads = e_loads; e.fl = e_fl; e.bs = e_bs; e.bub = e_bub;
    e.to = m_to; e.chk_cnt = chk; e.sc = m_sc; e.fc = m_fc;
    exp_q.push_back(e);
    n_vec++;
    if (rst) begin
      m_sc = 16'd0; m_fc = 8'd0; m_to = 1'b0;
    end else begin
      if (!e_loads[4] && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (e_fl) m_fc = m_fc + 8'd1;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 1);
  endtask

  task automatic chk1(input string name, input int idx, input logic [15:0] got,
                      input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  // Monitor: the combinational outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk1("loads", e.idx, 16'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}),
           16'(e.loads));
      chk1("flush", e.idx, 16'(flush), 16'(e.fl));
      chk1("branch_stall", e.idx, 16'(branch_stall), 16'(e.bs));
      chk1("bubble_id_ex", e.idx, 16'(bubble_id_ex), 16'(e.bub));
      if (e.chk_cnt) begin
        chk1("ind_timeout", e.idx, 16'(ind_timeout), 16'(e.to));
        chk1("stall_cycles", e.idx, stall_cycles, e.sc);
        chk1("flush_count", e.idx, 16'(flush_count), 16'(e.fc));
      end
    end
  end

  initial begin
    int guard;
    // Reset for two cycles; registers are unknown during the first.
    cyc(1, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0, 1);
    idle(); idle();

    // Load-use for one cycle.
    cyc(0, 0, 0, 1, 0, 0, 0, LU, 0, 0, 1, 1);
    idle();

    // Indirect in ID at cycle 0, resolved at cycle 3.
    cyc(0, 0, 0, 0, 0, 1, 0, PCOFF, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, PCOFF, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, PCOFF, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, ALL, 0, 0, 0, 1);
    idle();

    // Freeze cycles 0-4 with a mispredict at cycle 2; single flush at cycle 5.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, (i == 2), 0, 0, NONE, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, ALL, 1, 0, 0, 1);
    idle();

    // Unresolved indirect: 8 non-frozen wait cycles with a 2-cycle freeze inside.
    cyc(0, 0, 0, 0, 0, 1, 0, PCOFF, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, PCOFF, 0, 1, 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, 0, 0, NONE, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, PCOFF, 0, 1, 0, 1);
    m_to = 1'b1;
    idle(); idle();

    // Mispredict and indirect_resolved together in IND_WAIT: flush wins.
    cyc(0, 0, 0, 0, 0, 1, 0, PCOFF, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 1, ALL, 1, 0, 0, 1);
    idle();

    // Mispredict beats load-use; single icache stall.
    cyc(0, 0, 0, 1, 1, 0, 0, ALL, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, PCOFF, 0, 0, 0, 1);

    // Indirect resolved in the same cycle it reaches ID: no wait.
    cyc(0, 0, 0, 0, 0, 1, 1, ALL, 0, 0, 0, 1);
    idle();

    // Reset mid-IND_WAIT discards the wait and clears ind_timeout.
    cyc(0, 0, 0, 0, 0, 1, 0, PCOFF, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0, 1);
    idle();

    // Reset with a pending mispredict discards it.
    cyc(0, 0, 1, 0, 1, 0, 0, NONE, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0, 1);
    idle(); idle();

    // 256 mispredict pulses wrap flush_count back to 0.
    for (int i = 0; i < 256; i++) cyc(0, 0, 0, 0, 1, 0, 0, ALL, 1, 0, 0, 1);
    idle();

    // 70000 icache stall cycles saturate stall_cycles.
    for (int i = 0; i < 70000; i++) cyc(0, 1, 0, 0, 0, 0, 0, PCOFF, 0, 0, 0, 1);
    idle(); idle();

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
# if_id_hazard_ctrl

Pipeline sequencing controller for the five-stage LC-3b core. Generates the per-stage load enables, the front-end `flush`, the `branch_stall` nop-injection request and the ID/EX bubble from cache stall, load-use, indirect-branch and mispredict events. It drives the IF/ID state register (`load_if_id`, `flush`, `branch_stall`) and the PC/ID-EX/EX-MEM/MEM-WB load inputs. Two performance counters are exposed for debug.

## Interface
- `IND_TIMEOUT`, default 8: maximum IND_WAIT cycles before forced exit (range 2..15).
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `icache_stall`  in  1  fetch not complete this cycle.
- `dcache_stall`  in  1  MEM-stage access not complete; freezes the pipeline.
- `load_use`  in  1  ID instruction sources the destination of a load in EX.
- `mispredict`  in  1  one-cycle pulse: resolved branch disagrees with its prediction.
- `indirect_in_id`  in  1  ID holds JMP/JSRR/TRAP (target unknown until EX).
- `indirect_resolved`  in  1  one-cycle pulse: indirect target available to PC mux.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb`  out  1 each  stage load enables.
- `flush`  out  1  clear IF/ID and ID/EX contents.
- `branch_stall`  out  1  load a nop into IF/ID.
- `bubble_id_ex`  out  1  load a nop into ID/EX.
- `ind_timeout`  out  1  sticky: IND_WAIT watchdog expired.
- `stall_cycles`  out  16  saturating count of cycles with `load_pc`=0.
- `flush_count`  out  8  wrapping count of `flush` pulses.

## Operation
- State: RUN, IND_WAIT; plus `pend_mp` flag, 4-bit wait counter, and the two counters.
- Outputs are combinational from state, `pend_mp` and inputs. Priority, highest first:
  1. `reset`: all loads, `flush`, `branch_stall`, `bubble_id_ex` = 0.
  2. `dcache_stall`: all loads = 0, `flush` = 0, `branch_stall` = 0. State, wait counter held. A `mispredict` this cycle sets `pend_mp`.
  3. mp = `mispredict` | `pend_mp`: `flush` = 1, all loads = 1. Clear `pend_mp` and wait counter; next state RUN (also from IND_WAIT).
  4. IND_WAIT: `branch_stall` = 1, `load_pc` = 0, other loads = 1. On `indirect_resolved`: `load_pc` = 1, `branch_stall` = 0, next RUN. Otherwise, when the wait counter reaches IND_TIMEOUT-1: set `ind_timeout`, next RUN.
  5. RUN with `load_use`: `load_pc` = 0, `load_if_id` = 0, `bubble_id_ex` = 1, other loads = 1.
  6. RUN with `indirect_in_id` and no `indirect_resolved`: `branch_stall` = 1, `load_pc` = 0, other loads = 1. Next state IND_WAIT; clear wait counter.
  7. RUN with `icache_stall`: `load_pc` = 0, other loads = 1. IF/ID self-zeros its input on `icache_stall`.
  8. Otherwise all loads = 1.
- `flush` never coincides with `branch_stall` or `bubble_id_ex`.
- The wait counter increments each non-frozen IND_WAIT cycle.
- `stall_cycles` increments when `load_pc` = 0 and `reset` = 0, saturating at 16'hFFFF.
- `flush_count` increments on each `flush` = 1 cycle and wraps from 8'hFF to 0.

## Timing
- All outputs respond in the same cycle as their inputs; state takes effect next edge.
- Reset: state RUN, `pend_mp` = 0, wait counter = 0, `ind_timeout` = 0, `stall_cycles` = 0, `flush_count` = 0. Reset mid-IND_WAIT or with `pend_mp` set discards both.
- Mispredict under freeze: `flush` asserts on the first cycle with `dcache_stall` = 0, exactly once.
- `mispredict` with `indirect_resolved` in the same cycle: flush wins; next RUN.
- Indirect stall latency: 1 (RUN) + N (IND_WAIT) cycles of `load_pc` = 0, where N counts cycles up to and excluding the `indirect_resolved` cycle.

## Test plan
- Reset held 2 cycles, then idle inputs: all loads = 1, `flush_count` = 0, `stall_cycles` = 0.
- `load_use` for 1 cycle: `load_pc` = `load_if_id` = 0, `bubble_id_ex` = 1 that cycle; `stall_cycles` = 1.
- `indirect_in_id` at cycle 0, `indirect_resolved` at cycle 3: `branch_stall` = 1 in cycles 0-2; `load_pc` = 1 in cycle 3; state RUN at cycle 4; `stall_cycles` = 3.
- `dcache_stall` for cycles 0-4 with `mispredict` at cycle 2: all loads = 0 in cycles 0-4; single `flush` at cycle 5; `flush_count` = 1.
- Indirect with no resolve, IND_TIMEOUT = 8: RUN after 8 wait cycles; `ind_timeout` = 1 and stays set until reset.
- 256 mispredict pulses: `flush_count` wraps to 0; 70000 `icache_stall` cycles: `stall_cycles` = 16'hFFFF.
